// File: rtl/spi_ch_readout_shifter.sv
// SPI slave readout stage: fetches the addressed channel register and shifts it MSB-first on miso.
// Optional odd-parity bit per byte when READOUT_PARITY_EN is defined.
module spi_ch_readout_shifter #(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned REGS_PER_CH = 7,
  parameter int unsigned BASE_ADDR   = 11,
  parameter int unsigned DATA_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cs,
  input  logic [6:0]               addr,
  input  logic                     addr_valid,
  input  logic [2:0]               select_reg,
  input  logic [NUM_CH*DATA_W-1:0] ch_rdata,
  output logic [6:0]               rd_addr,
  output logic                     miso,
  output logic                     byte_done,
  output logic                     rd_err
);

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned LAST_ADDR = BASE_ADDR + NUM_CH * REGS_PER_CH - 1;
  localparam int unsigned ADDR_MAX  = (1 << ADDR_W) - 1;
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned REG_W     = (REGS_PER_CH > 1) ? $clog2(REGS_PER_CH) : 1;
`ifdef READOUT_PARITY_EN
  localparam int unsigned PAR_W     = 1;
`else
  localparam int unsigned PAR_W     = 0;
`endif
  localparam int unsigned SR_W      = DATA_W + PAR_W;
  localparam int unsigned CNT_W     = $clog2(SR_W);
  localparam int unsigned LAST_BIT  = SR_W - 1;
  localparam int unsigned MID_BIT   = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [SR_W-1:0]     sr_q, sr_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CH_W-1:0]     ch_idx_q, ch_idx_d;
  logic [REG_W-1:0]    reg_idx_q, reg_idx_d;
  logic                miso_q, miso_d;
  logic                byte_done_q, byte_done_d;
  logic                rd_err_q, rd_err_d;

  logic [CH_W-1:0]     ch_calc, ch_nx, fetch_ch;
  logic [REG_W-1:0]    reg_calc, reg_nx;
  logic [ADDR_W-1:0]   addr_nx;
  logic                in_range, fetch_ok;
  logic [DATA_W-1:0]   fetch_data;
  logic [SR_W-1:0]     fetch_frame;

  // Initial channel/register index by range compare against each channel's base address
  always_comb begin
    ch_calc  = '0;
    reg_calc = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(rd_addr_q) >= BASE_ADDR + k * REGS_PER_CH) begin
        ch_calc  = CH_W'(k);
        reg_calc = REG_W'(32'(rd_addr_q) - BASE_ADDR - k * REGS_PER_CH);
      end
    end
  end

  assign in_range   = (rd_addr_q >= ADDR_W'(BASE_ADDR)) && (rd_addr_q <= ADDR_W'(LAST_ADDR));
  assign fetch_ch   = (state_q == ST_LOAD) ? ch_calc : ch_idx_q;
  assign fetch_ok   = in_range && (select_reg != {SEL_W{1'b1}});
  assign fetch_data = fetch_ok ? ch_rdata[32'(fetch_ch) * DATA_W +: DATA_W] : '0;

`ifdef READOUT_PARITY_EN
  assign fetch_frame = {fetch_data, ~^fetch_data};
`else
  assign fetch_frame = fetch_data;
`endif

  // Mid-byte address advance; out-of-range addresses climb and saturate, ch/reg tracking resumes at BASE_ADDR
  always_comb begin
    addr_nx = rd_addr_q;
    ch_nx   = '0;
    reg_nx  = '0;
    if (rd_addr_q == ADDR_W'(LAST_ADDR)) begin
      addr_nx = ADDR_W'(BASE_ADDR);
    end else if (in_range) begin
      addr_nx = rd_addr_q + ADDR_W'(1);
      if (reg_idx_q == REG_W'(REGS_PER_CH - 1)) begin
        ch_nx = ch_idx_q + CH_W'(1);
      end else begin
        ch_nx  = ch_idx_q;
        reg_nx = reg_idx_q + REG_W'(1);
      end
    end else if (rd_addr_q != ADDR_W'(ADDR_MAX)) begin
      addr_nx = rd_addr_q + ADDR_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    ch_idx_d  = ch_idx_q;
    reg_idx_d = reg_idx_q;
    rd_err_d  = rd_err_q;

    if (!cs) begin
      state_d  = ST_IDLE;
      rd_err_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (addr_valid) begin
            rd_addr_d = addr;
            state_d   = ST_LOAD;
          end
        end
        ST_LOAD: begin
          sr_d      = fetch_frame;
          bit_cnt_d = '0;
          ch_idx_d  = ch_calc;
          reg_idx_d = reg_calc;
          rd_err_d  = rd_err_q | ~fetch_ok;
          state_d   = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (bit_cnt_q == CNT_W'(LAST_BIT)) begin
            sr_d      = fetch_frame;
            bit_cnt_d = '0;
            rd_err_d  = rd_err_q | ~fetch_ok;
          end else begin
            sr_d      = {sr_q[SR_W-2:0], 1'b0};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
          if (bit_cnt_q == CNT_W'(MID_BIT)) begin
            rd_addr_d = addr_nx;
            ch_idx_d  = ch_nx;
            reg_idx_d = reg_nx;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    miso_d      = (state_d == ST_SHIFT) && sr_d[SR_W-1];
    byte_done_d = (state_d == ST_SHIFT) && (bit_cnt_d == CNT_W'(LAST_BIT));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_addr_q   <= '0;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      ch_idx_q    <= '0;
      reg_idx_q   <= '0;
      miso_q      <= 1'b0;
      byte_done_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_addr_q   <= rd_addr_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      ch_idx_q    <= ch_idx_d;
      reg_idx_q   <= reg_idx_d;
      miso_q      <= miso_d;
      byte_done_q <= byte_done_d;
      rd_err_q    <= rd_err_d;
    end
  end

  assign rd_addr   = rd_addr_q;
  assign miso      = miso_q;
  assign byte_done = byte_done_q;
  assign rd_err    = rd_err_q;

endmodule
